// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - button-driven operand entry, restoring divider and result display sequencer
module div_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_next,
  input  logic             tick_up,
  input  logic             tick_down,
  output logic [WIDTH-1:0] leds,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [2:0] {
    LOAD_NUM = 3'd0,
    LOAD_DEN = 3'd1,
    DIVIDE   = 3'd2,
    SHOW_QUO = 3'd3,
    SHOW_REM = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE = 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    iter;

  // Up and down together cancel; only a lone tick edits the operand.
  logic edit_up;
  logic edit_down;
  assign edit_up   = tick_up & ~tick_down;
  assign edit_down = tick_down & ~tick_up;

  // One restoring step: shift {rem,quo} left, trial-subtract den.
  logic [WIDTH:0] rem_shift;
  logic           rem_ge;
  logic           step_last;
  assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign rem_ge    = {rem, quo[WIDTH-1]} >= {2'b00, den};
  assign step_last = (iter == CW'(WIDTH - 1));

  // Next-state decode; tick_next takes priority over edits in load states.
  always_comb begin
    state_next = state;
    case (state)
      LOAD_NUM: if (tick_next) state_next = LOAD_DEN;
      LOAD_DEN: begin
        if (tick_next) begin
          if (den == '0) state_next = ERROR;
          else           state_next = DIVIDE;
        end
      end
      DIVIDE:   if (step_last) state_next = SHOW_QUO;
      SHOW_QUO: if (tick_next) state_next = SHOW_REM;
      SHOW_REM: if (tick_next) state_next = LOAD_NUM;
      ERROR:    if (tick_next) state_next = LOAD_DEN;
      default:  state_next = LOAD_NUM;
    endcase
  end

  // State register and the done pulse marking the DIVIDE -> SHOW_QUO edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD_NUM;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == DIVIDE) && step_last;
    end
  end

  // Operand counters and the iterative divider datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num  <= '0;
      den  <= '0;
      quo  <= '0;
      rem  <= '0;
      iter <= '0;
    end else begin
      case (state)
        LOAD_NUM: begin
          if (!tick_next) begin
            if (edit_up)        num <= num + ONE;
            else if (edit_down) num <= num - ONE;
          end
        end
        LOAD_DEN: begin
          if (tick_next) begin
            if (den != '0) begin
              rem  <= '0;
              quo  <= num;
              iter <= '0;
            end
          end else if (edit_up) begin
            den <= den + ONE;
          end else if (edit_down) begin
            den <= den - ONE;
          end
        end
        DIVIDE: begin
          rem  <= rem_ge ? (rem_shift - {1'b0, den}) : rem_shift;
          quo  <= {quo[WIDTH-2:0], rem_ge};
          iter <= iter + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Display and status outputs decoded from registered state only.
  always_comb begin
    leds     = '0;
    phase    = state;
    busy     = (state == DIVIDE);
    div_zero = (state == ERROR);
    case (state)
      LOAD_NUM: leds = num;
      LOAD_DEN: leds = den;
      SHOW_QUO: leds = quo;
      SHOW_REM: leds = rem[WIDTH-1:0];
      ERROR:    leds = '1;
      default:  leds = '0;
    endcase
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - scoreboard bench for div_seq_ctrl output events
module tb_div_seq_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic [2:0] ph;
    logic [3:0] led;
    logic       b;
    logic       d;
    logic       z;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_next = 1'b0;
  logic       tick_up = 1'b0;
  logic       tick_down = 1'b0;
  logic [3:0] leds;
  logic [2:0] phase;
  logic       busy;
  logic       done;
  logic       div_zero;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_next (tick_next),
    .tick_up   (tick_up),
    .tick_down (tick_down),
    .leds      (leds),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  ev_t  prev = '0;
  ev_t  cur;
  ev_t  popped;
  int   div_cycles = 0;

  logic [3:0] m_num = 4'd0;
  logic [3:0] m_den = 4'd0;
  logic [2:0] m_ph = 3'd0;
  logic [3:0] m_q = 4'd0;
  logic [3:0] m_r = 4'd0;
  logic       m_abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] p, input logic [3:0] l, input logic b, input logic d, input logic z);
    ev_t e;
    e.ph = p; e.led = l; e.b = b; e.d = d; e.z = z;
    exp_q.push_back(e);
  endtask

  // Monitor: every change of the visible outputs consumes one expected event.
  always @(negedge clk) begin
    cur = {phase, leds, busy, done, div_zero};
    if (phase == 3'd2) begin
      div_cycles++;
    end else begin
      if (prev.ph == 3'd2 && phase == 3'd3) check("divide_len", div_cycles, W);
      div_cycles = 0;
    end
    if (cur !== prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got %0h expected none at %0t", cur, $time);
      end else begin
        popped = exp_q.pop_front();
        check("event", cur, popped);
      end
      prev = cur;
    end
  end

  // Drive one tick pattern for one cycle and queue the outputs it should cause.
  task automatic tick(input logic u, input logic d, input logic n);
    @(posedge clk);
    #1;
    tick_up = u; tick_down = d; tick_next = n;
    case (m_ph)
      3'd0: begin
        if (n) begin
          m_ph = 3'd1; push(3'd1, m_den, 0, 0, 0);
        end else if (u && !d) begin
          m_num = m_num + 4'd1; push(3'd0, m_num, 0, 0, 0);
        end else if (d && !u) begin
          m_num = m_num - 4'd1; push(3'd0, m_num, 0, 0, 0);
        end
      end
      3'd1: begin
        if (n) begin
          if (m_den == 4'd0) begin
            m_ph = 3'd5; push(3'd5, 4'hF, 0, 0, 1);
          end else begin
            push(3'd2, 4'd0, 1, 0, 0);
            if (m_abort) begin
              m_ph = 3'd2;
            end else begin
              m_ph = 3'd3;
              push(3'd3, m_q, 0, 1, 0);
              push(3'd3, m_q, 0, 0, 0);
            end
          end
        end else if (u && !d) begin
          m_den = m_den + 4'd1; push(3'd1, m_den, 0, 0, 0);
        end else if (d && !u) begin
          m_den = m_den - 4'd1; push(3'd1, m_den, 0, 0, 0);
        end
      end
      3'd3: if (n) begin m_ph = 3'd4; push(3'd4, m_r, 0, 0, 0); end
      3'd4: if (n) begin m_ph = 3'd0; push(3'd0, m_num, 0, 0, 0); end
      3'd5: if (n) begin m_ph = 3'd1; push(3'd1, m_den, 0, 0, 0); end
      default: ;
    endcase
    @(posedge clk);
    #1;
    tick_up = 1'b0; tick_down = 1'b0; tick_next = 1'b0;
  endtask

  task automatic set_num(input logic [3:0] v);
    while (m_num != v) tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_den(input logic [3:0] v);
    while (m_den != v) tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_div(input logic [3:0] n, input logic [3:0] d, input logic [3:0] q, input logic [3:0] r);
    set_num(n);
    tick(1'b0, 1'b0, 1'b1);
    set_den(d);
    m_q = q; m_r = r;
    tick(1'b0, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 check("reset_outputs", {phase, leds, busy, done, div_zero}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    run_div(4'd13, 4'd4, 4'd3, 4'd1);
    run_div(4'd15, 4'd1, 4'd15, 4'd0);
    run_div(4'd3, 4'd9, 4'd0, 4'd3);

    set_num(4'd0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    set_den(4'd0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    set_den(4'd5);
    m_abort = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    push(3'd0, 4'd0, 0, 0, 0);
    #1 check("async_abort", {phase, leds, busy, done, div_zero}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_ph = 3'd0; m_num = 4'd0; m_den = 4'd0; m_abort = 1'b0;
    repeat (8) @(posedge clk);

    for (int n = 0; n < 16; n++) begin
      for (int d = 1; d < 16; d++) begin
        run_div(4'(n), 4'(d), 4'(n / d), 4'(n % d));
      end
    end

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
